// File: rtl/fmmu_pkg.sv
// rtl/fmmu_pkg.sv - FMMU command codes, config register map, type bits and FSM encoding
package fmmu_pkg;

  localparam logic [7:0] CMD_LRD = 8'h0A;
  localparam logic [7:0] CMD_LWR = 8'h0B;
  localparam logic [7:0] CMD_LRW = 8'h0C;

  localparam logic [3:0] REG_LOG_START0 = 4'h0;
  localparam logic [3:0] REG_LOG_START1 = 4'h1;
  localparam logic [3:0] REG_LOG_START2 = 4'h2;
  localparam logic [3:0] REG_LOG_START3 = 4'h3;
  localparam logic [3:0] REG_LOG_LEN0   = 4'h4;
  localparam logic [3:0] REG_LOG_LEN1   = 4'h5;
  localparam logic [3:0] REG_PHYS0      = 4'h8;
  localparam logic [3:0] REG_PHYS1      = 4'h9;
  localparam logic [3:0] REG_TYPE       = 4'hB;
  localparam logic [3:0] REG_ENABLE     = 4'hC;

  localparam int TYPE_RD_BIT = 0;
  localparam int TYPE_WR_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_DONE = 2'd2
  } fmmu_state_e;

  function automatic logic is_logical(input logic [7:0] cmd);
    return (cmd == CMD_LRD) || (cmd == CMD_LWR) || (cmd == CMD_LRW);
  endfunction

endpackage

// File: rtl/fmmu_channel.sv
// rtl/fmmu_channel.sv - one FMMU channel: config registers plus window match and address translation
module fmmu_channel import fmmu_pkg::*; #(
  parameter int CH_IDX = 0,
  parameter int BUS_AW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [7:0]        cfg_addr,
  input  logic [7:0]        cfg_wdata,
  input  logic [31:0]       la,
  output logic              hit,
  output logic              hit_rd,
  output logic              hit_wr,
  output logic [BUS_AW-1:0] phys_addr
);

  logic [31:0] log_start_q, log_start_d;
  logic [15:0] log_len_q, log_len_d;
  logic [15:0] phys_start_q, phys_start_d;
  logic [1:0]  type_q, type_d;
  logic        enable_q, enable_d;
  logic [31:0] delta;

  // Byte-wide config writes addressed to this channel; unmapped offsets are dropped.
  always_comb begin
    log_start_d  = log_start_q;
    log_len_d    = log_len_q;
    phys_start_d = phys_start_q;
    type_d       = type_q;
    enable_d     = enable_q;
    if (cfg_wr && (cfg_addr[7:4] == 4'(CH_IDX))) begin
      case (cfg_addr[3:0])
        REG_LOG_START0: log_start_d[7:0]   = cfg_wdata;
        REG_LOG_START1: log_start_d[15:8]  = cfg_wdata;
        REG_LOG_START2: log_start_d[23:16] = cfg_wdata;
        REG_LOG_START3: log_start_d[31:24] = cfg_wdata;
        REG_LOG_LEN0:   log_len_d[7:0]     = cfg_wdata;
        REG_LOG_LEN1:   log_len_d[15:8]    = cfg_wdata;
        REG_PHYS0:      phys_start_d[7:0]  = cfg_wdata;
        REG_PHYS1:      phys_start_d[15:8] = cfg_wdata;
        REG_TYPE:       type_d             = cfg_wdata[1:0];
        REG_ENABLE:     enable_d           = cfg_wdata[0];
        default: ;
      endcase
    end
  end

  // Config register file; reset leaves the channel disabled with an empty window.
  always_ff @(posedge clk) begin
    if (rst) begin
      log_start_q  <= '0;
      log_len_q    <= '0;
      phys_start_q <= '0;
      type_q       <= '0;
      enable_q     <= 1'b0;
    end else begin
      log_start_q  <= log_start_d;
      log_len_q    <= log_len_d;
      phys_start_q <= phys_start_d;
      type_q       <= type_d;
      enable_q     <= enable_d;
    end
  end

  // Modular distance into the window, so a window straddling 2^32 still matches.
  assign delta     = la - log_start_q;
  assign hit       = enable_q && (log_len_q != 16'h0) && (delta < {16'h0, log_len_q});
  assign hit_rd    = hit && type_q[TYPE_RD_BIT];
  assign hit_wr    = hit && type_q[TYPE_WR_BIT];
  assign phys_addr = BUS_AW'({16'h0, phys_start_q} + delta);

endmodule

// File: rtl/fmmu_mapper.sv
// rtl/fmmu_mapper.sv - N-channel FMMU mapping logical datagram bytes onto the physical bus
module fmmu_mapper import fmmu_pkg::*; #(
  parameter int NUM_FMMU = 8,
  parameter int LEN_W    = 11,
  parameter int BUS_AW   = 16
) (
  input  logic              rxc,
  input  logic              RST,
  input  logic              dgram_start,
  input  logic [7:0]        sub_command,
  input  logic [31:0]       sub_address,
  input  logic [LEN_W-1:0]  sub_len,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [7:0]        bus_data_in,
  input  logic              cfg_wr,
  input  logic [7:0]        cfg_addr,
  input  logic [7:0]        cfg_wdata,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic [BUS_AW-1:0] bus_address,
  output logic [7:0]        bus_data_out,
  output logic              busy,
  output logic              wkc_valid,
  output logic [1:0]        wkc_inc
);

  fmmu_state_e       state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [31:0]       addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  off_q, off_d;
  logic              rd_flag_q, rd_flag_d;
  logic              wr_flag_q, wr_flag_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_sel_bus_q, tx_sel_bus_d;

  logic [31:0]       la;
  logic [NUM_FMMU-1:0] ch_hit, ch_rd, ch_wr;
  logic [BUS_AW-1:0] ch_addr [NUM_FMMU];
  logic              sel_rd, sel_wr;
  logic [BUS_AW-1:0] sel_addr;
  logic              accept, need_rd, need_wr, rd_now, wr_now;

  assign la = addr_q + 32'(off_q);

  for (genvar g = 0; g < NUM_FMMU; g++) begin : g_ch
    fmmu_channel #(.CH_IDX(g), .BUS_AW(BUS_AW)) u_ch (
      .clk       (rxc),
      .rst       (RST),
      .cfg_wr    (cfg_wr),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .la        (la),
      .hit       (ch_hit[g]),
      .hit_rd    (ch_rd[g]),
      .hit_wr    (ch_wr[g]),
      .phys_addr (ch_addr[g])
    );
  end

  // Lowest-index window hit owns the byte; type bits of that channel alone decide access.
  always_comb begin
    sel_rd   = 1'b0;
    sel_wr   = 1'b0;
    sel_addr = '0;
    for (int n = NUM_FMMU - 1; n >= 0; n--) begin
      if (ch_hit[n]) begin
        sel_rd   = ch_rd[n];
        sel_wr   = ch_wr[n];
        sel_addr = ch_addr[n];
      end
    end
  end

  // A byte arriving alongside a new header belongs to no datagram and is not mapped.
  assign accept  = (state_q == ST_DATA) && rx_valid && !dgram_start;
  assign need_rd = (cmd_q == CMD_LRD) || (cmd_q == CMD_LRW);
  assign need_wr = (cmd_q == CMD_LWR) || (cmd_q == CMD_LRW);
  assign rd_now  = accept && sel_rd && need_rd;
  assign wr_now  = accept && sel_wr && need_wr;

  // Next state, header latch, offset walk and WKC flags; a new header always restarts.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    len_d     = len_q;
    off_d     = off_q;
    rd_flag_d = rd_flag_q | rd_now;
    wr_flag_d = wr_flag_q | wr_now;
    case (state_q)
      ST_DATA: begin
        if (accept) begin
          off_d = off_q + LEN_W'(1);
          if ((off_q + LEN_W'(1)) == len_q) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (dgram_start) begin
      state_d = ST_IDLE;
      if (is_logical(sub_command)) begin
        cmd_d     = sub_command;
        addr_d    = sub_address;
        len_d     = sub_len;
        off_d     = '0;
        rd_flag_d = 1'b0;
        wr_flag_d = 1'b0;
        state_d   = (sub_len == '0) ? ST_DONE : ST_DATA;
      end
    end
    tx_valid_d   = rx_valid;
    tx_byte_d    = rx_data;
    tx_sel_bus_d = rd_now;
  end

  // State and pipeline registers.
  always_ff @(posedge rxc) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      off_q        <= '0;
      rd_flag_q    <= 1'b0;
      wr_flag_q    <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_byte_q    <= '0;
      tx_sel_bus_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      off_q        <= off_d;
      rd_flag_q    <= rd_flag_d;
      wr_flag_q    <= wr_flag_d;
      tx_valid_q   <= tx_valid_d;
      tx_byte_q    <= tx_byte_d;
      tx_sel_bus_q <= tx_sel_bus_d;
    end
  end

  assign bus_rd       = rd_now;
  assign bus_wr       = wr_now;
  assign bus_address  = (rd_now || wr_now) ? sel_addr : '0;
  assign bus_data_out = wr_now ? rx_data : 8'h00;
  assign tx_valid     = tx_valid_q;
  assign tx_data      = tx_sel_bus_q ? bus_data_in : tx_byte_q;
  assign busy         = (state_q != ST_IDLE);
  assign wkc_valid    = (state_q == ST_DONE) && !dgram_start;

  // WKC weighting: LRW counts a read as 1 and a write as 2.
  always_comb begin
    wkc_inc = 2'b00;
    if (wkc_valid) begin
      case (cmd_q)
        CMD_LRD: wkc_inc = {1'b0, rd_flag_q};
        CMD_LWR: wkc_inc = {1'b0, wr_flag_q};
        default: wkc_inc = {wr_flag_q, rd_flag_q};
      endcase
    end
  end

endmodule

// File: tb/tb_fmmu_mapper.sv
// tb/tb_fmmu_mapper.sv - randomized self-checking bench for fmmu_mapper against a datagram-level model
module tb_fmmu_mapper;
  localparam int NUM_FMMU = 8;
  localparam int LEN_W    = 11;
  localparam int BUS_AW   = 16;

  logic              rxc = 1'b0;
  logic              RST = 1'b1;
  logic              dgram_start = 1'b0;
  logic [7:0]        sub_command = '0;
  logic [31:0]       sub_address = '0;
  logic [LEN_W-1:0]  sub_len = '0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = '0;
  logic [7:0]        bus_data_in = '0;
  logic              cfg_wr = 1'b0;
  logic [7:0]        cfg_addr = '0;
  logic [7:0]        cfg_wdata = '0;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              bus_rd, bus_wr;
  logic [BUS_AW-1:0] bus_address;
  logic [7:0]        bus_data_out;
  logic              busy, wkc_valid;
  logic [1:0]        wkc_inc;

  always #5 rxc = ~rxc;

  fmmu_mapper #(.NUM_FMMU(NUM_FMMU), .LEN_W(LEN_W), .BUS_AW(BUS_AW)) dut (
    .rxc(rxc), .RST(RST), .dgram_start(dgram_start), .sub_command(sub_command),
    .sub_address(sub_address), .sub_len(sub_len), .rx_valid(rx_valid), .rx_data(rx_data),
    .bus_data_in(bus_data_in), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_address(bus_address), .bus_data_out(bus_data_out), .busy(busy),
    .wkc_valid(wkc_valid), .wkc_inc(wkc_inc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: channel config as written, datagram progress as plain counters.
  logic [31:0] m_log  [16];
  logic [15:0] m_len  [16];
  logic [15:0] m_phys [16];
  logic [1:0]  m_type [16];
  bit          m_en   [16];
  bit          m_active, m_done, m_rdf, m_wrf;
  logic [7:0]  m_cmd;
  logic [31:0] m_addr;
  int          m_dlen, m_off;
  bit          p_rv, p_rd;
  logic [15:0] p_addr;
  logic [7:0]  p_data;
  logic [7:0]  pay [64];

  function automatic logic [7:0] rdval(input logic [15:0] a);
    return 8'hA0 + a[7:0];
  endfunction

  function automatic bit logical(input logic [7:0] c);
    return (c == 8'h0A) || (c == 8'h0B) || (c == 8'h0C);
  endfunction

  function automatic void model_clear();
    for (int n = 0; n < 16; n++) begin
      m_log[n] = 0; m_len[n] = 0; m_phys[n] = 0; m_type[n] = 0; m_en[n] = 0;
    end
    m_active = 0; m_done = 0; m_rdf = 0; m_wrf = 0;
    p_rv = 0; p_rd = 0; p_addr = 0; p_data = 0;
  endfunction

  function automatic void cfg_apply(input logic [7:0] ca, input logic [7:0] cd);
    int ch;
    ch = int'(ca[7:4]);
    if (ch < NUM_FMMU) begin
      case (ca[3:0])
        4'h0: m_log[ch][7:0]   = cd;
        4'h1: m_log[ch][15:8]  = cd;
        4'h2: m_log[ch][23:16] = cd;
        4'h3: m_log[ch][31:24] = cd;
        4'h4: m_len[ch][7:0]   = cd;
        4'h5: m_len[ch][15:8]  = cd;
        4'h8: m_phys[ch][7:0]  = cd;
        4'h9: m_phys[ch][15:8] = cd;
        4'hB: m_type[ch]       = cd[1:0];
        4'hC: m_en[ch]         = cd[0];
        default: ;
      endcase
    end
  endfunction

  function automatic void lookup(input logic [31:0] la, input logic [7:0] cmd,
                                 output bit rd, output bit wr, output logic [15:0] a);
    bit found;
    logic [31:0] d;
    found = 0; rd = 0; wr = 0; a = 0;
    for (int n = 0; n < NUM_FMMU; n++) begin
      d = la - m_log[n];
      if (!found && m_en[n] && m_len[n] != 0 && d < {16'h0, m_len[n]}) begin
        found = 1;
        rd = (cmd == 8'h0A || cmd == 8'h0C) && m_type[n][0];
        wr = (cmd == 8'h0B || cmd == 8'h0C) && m_type[n][1];
        a  = m_phys[n] + d[15:0];
      end
    end
  endfunction

  function automatic logic [1:0] wkc_of();
    int w;
    if (m_cmd == 8'h0A)      w = int'(m_rdf);
    else if (m_cmd == 8'h0B) w = int'(m_wrf);
    else                     w = int'(m_rdf) + 2 * int'(m_wrf);
    return 2'(w);
  endfunction

  task automatic step(input bit ds, input logic [7:0] cmd, input logic [31:0] adr, input int len,
                      input bit rv, input logic [7:0] rd, input bit cw, input logic [7:0] ca,
                      input logic [7:0] cd);
    bit e_rd, e_wr, e_wkcv, e_busy;
    logic [15:0] e_addr;
    logic [1:0]  e_wkc;
    e_rd = 0; e_wr = 0; e_addr = 0;
    e_wkcv = m_done && !ds;
    e_wkc  = e_wkcv ? wkc_of() : 2'd0;
    e_busy = m_active || m_done;
    if (m_active && rv && !ds) lookup(m_addr + 32'(m_off), m_cmd, e_rd, e_wr, e_addr);
    @(negedge rxc);
    dgram_start = ds; sub_command = cmd; sub_address = adr; sub_len = LEN_W'(len);
    rx_valid = rv; rx_data = rd; cfg_wr = cw; cfg_addr = ca; cfg_wdata = cd;
    bus_data_in = p_rd ? rdval(p_addr) : 8'($urandom);
    #1;
    chk_eq("tx_valid", tx_valid, p_rv);
    if (p_rv) chk_eq("tx_data", tx_data, p_rd ? rdval(p_addr) : p_data);
    chk_eq("bus_rd", bus_rd, e_rd);
    chk_eq("bus_wr", bus_wr, e_wr);
    if (e_rd || e_wr) chk_eq("bus_address", bus_address, e_addr);
    if (e_wr) chk_eq("bus_data_out", bus_data_out, rd);
    chk_eq("busy", busy, e_busy);
    chk_eq("wkc_valid", wkc_valid, e_wkcv);
    if (e_wkcv) chk_eq("wkc_inc", wkc_inc, e_wkc);
    p_rv = rv; p_rd = e_rd; p_addr = e_addr; p_data = rd;
    m_done = 0;
    if (ds) begin
      m_active = 0;
      if (logical(cmd)) begin
        m_cmd = cmd; m_addr = adr; m_dlen = len; m_off = 0; m_rdf = 0; m_wrf = 0;
        if (len == 0) m_done = 1;
        else m_active = 1;
      end
    end else if (m_active && rv) begin
      m_rdf = m_rdf | e_rd;
      m_wrf = m_wrf | e_wr;
      m_off++;
      if (m_off == m_dlen) begin
        m_active = 0;
        m_done = 1;
      end
    end
    if (cw) cfg_apply(ca, cd);
  endtask

  task automatic idle();
    step(0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00);
  endtask

  task automatic cfg_byte(input int ch, input logic [3:0] r, input logic [7:0] d);
    step(0, 8'h00, 0, 0, 0, 8'h00, 1, {4'(ch), r}, d);
  endtask

  task automatic cfg_chan(input int ch, input logic [31:0] lg, input logic [15:0] ln,
                          input logic [15:0] ph, input logic [1:0] ty, input bit en);
    cfg_byte(ch, 4'h0, lg[7:0]);   cfg_byte(ch, 4'h1, lg[15:8]);
    cfg_byte(ch, 4'h2, lg[23:16]); cfg_byte(ch, 4'h3, lg[31:24]);
    cfg_byte(ch, 4'h4, ln[7:0]);   cfg_byte(ch, 4'h5, ln[15:8]);
    cfg_byte(ch, 4'h8, ph[7:0]);   cfg_byte(ch, 4'h9, ph[15:8]);
    cfg_byte(ch, 4'hB, {6'h0, ty}); cfg_byte(ch, 4'hC, {7'h0, en});
  endtask

  task automatic dgram(input logic [7:0] cmd, input logic [31:0] adr, input int len,
                       input int stop_at, input bit gaps);
    step(1, cmd, adr, len, 0, 8'h00, 0, 8'h00, 8'h00);
    for (int i = 0; i < len; i++) begin
      if (i == stop_at) return;
      if (gaps && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) idle();
        else cfg_byte($urandom_range(0, 15), 4'($urandom_range(0, 15)), 8'($urandom));
      end
      step(0, 8'h00, 0, 0, 1, pay[i], 0, 8'h00, 8'h00);
    end
    idle();
    idle();
  endtask

  task automatic do_reset();
    @(negedge rxc);
    RST = 1; dgram_start = 0; rx_valid = 0; rx_data = 0; cfg_wr = 0; cfg_addr = 0;
    cfg_wdata = 0; sub_command = 0; sub_address = 0; sub_len = 0; bus_data_in = 0;
    @(negedge rxc);
    RST = 0;
    #1;
    chk_eq("rst_tx_valid", tx_valid, 0);
    chk_eq("rst_tx_data", tx_data, 0);
    chk_eq("rst_bus_rd", bus_rd, 0);
    chk_eq("rst_bus_wr", bus_wr, 0);
    chk_eq("rst_bus_address", bus_address, 0);
    chk_eq("rst_bus_data_out", bus_data_out, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_wkc_valid", wkc_valid, 0);
    chk_eq("rst_wkc_inc", wkc_inc, 0);
    model_clear();
  endtask

  initial begin
    model_clear();
    for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
    do_reset();

    // LRD over ch0 with read data A0..A3
    cfg_chan(0, 32'h0000_1000, 16'd4, 16'h0100, 2'd1, 1);
    dgram(8'h0A, 32'h0000_1000, 4, -1, 0);

    // LWR straddling the start of ch2's window
    cfg_chan(2, 32'h0000_2000, 16'd2, 16'h0800, 2'd2, 1);
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    dgram(8'h0B, 32'h0000_1FFF, 4, -1, 0);

    // Overlapping ch1/ch3, LRW: lowest index wins, read+write on one byte
    cfg_chan(1, 32'h0000_3000, 16'd1, 16'h0010, 2'd3, 1);
    cfg_chan(3, 32'h0000_3000, 16'd1, 16'h0090, 2'd3, 1);
    dgram(8'h0C, 32'h0000_3000, 1, -1, 0);

    // Window crossing 2^32, then the same datagram with the channel disabled
    cfg_chan(0, 32'hFFFF_FFFE, 16'd4, 16'h0000, 2'd1, 1);
    dgram(8'h0A, 32'hFFFF_FFFF, 3, -1, 0);
    cfg_byte(0, 4'hC, 8'h00);
    dgram(8'h0A, 32'hFFFF_FFFF, 3, -1, 0);

    // Pass-through command, logical miss, zero-length datagram
    dgram(8'h01, 32'h0000_3000, 4, -1, 0);
    dgram(8'h0A, 32'h0000_5000, 3, -1, 0);
    dgram(8'h0A, 32'h0000_2000, 0, -1, 0);

    // Abort by new header mid-datagram
    dgram(8'h0B, 32'h0000_2000, 4, 1, 0);
    dgram(8'h0C, 32'h0000_3000, 1, -1, 0);

    // Reset mid-datagram clears config
    dgram(8'h0B, 32'h0000_2000, 4, 2, 0);
    do_reset();
    dgram(8'h0C, 32'h0000_3000, 1, -1, 0);

    // Randomized traffic with random windows, gaps, live config writes and aborts
    for (int it = 0; it < 150; it++) begin
      logic [31:0] base;
      logic [7:0]  cmd;
      int          sel;
      if ($urandom_range(0, 3) == 0) begin
        base = ($urandom_range(0, 1) == 0) ? 32'h0000_4000 : 32'hFFFF_FFF0;
        cfg_chan($urandom_range(0, NUM_FMMU - 1), base + 32'($urandom_range(0, 24)),
                 16'($urandom_range(0, 12)), 16'($urandom), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 4) != 0);
      end
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1: cmd = 8'h0A;
        2:    cmd = 8'h0B;
        3:    cmd = 8'h0C;
        4:    cmd = 8'h01;
        default: cmd = 8'($urandom);
      endcase
      base = ($urandom_range(0, 1) == 0) ? 32'h0000_4000 : 32'hFFFF_FFF0;
      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      dgram(cmd, base + 32'($urandom_range(0, 30)), $urandom_range(0, 8),
            ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
